// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: operation encodings, FSM/exception enums and small
// decode helpers shared by the load/store unit and its lane aligner.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_SKIP_OP,
    MEM_LOAD_OP,
    MEM_STORE_OP
  } memory_op_t;

  typedef enum logic [2:0] {
    LOAD_BYTE,
    LOAD_HALF,
    LOAD_WORD,
    LOAD_BYTEU,
    LOAD_HALFU,
    LOAD_WORDU,
    LOAD_DWORD
  } load_op_t;

  typedef enum logic [1:0] {
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD,
    STORE_DWORD
  } store_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    EXC_LOAD_MISALIGNED  = 2'd0,
    EXC_STORE_MISALIGNED = 2'd1,
    EXC_BUS_ERROR        = 2'd2,
    EXC_BUS_TIMEOUT      = 2'd3
  } lsu_exc_t;

  // Access size as log2(bytes): 0 byte, 1 half, 2 word, 3 dword.
  function automatic logic [1:0] load_size(load_op_t op);
    case (op)
      LOAD_BYTE, LOAD_BYTEU: load_size = 2'd0;
      LOAD_HALF, LOAD_HALFU: load_size = 2'd1;
      LOAD_WORD, LOAD_WORDU: load_size = 2'd2;
      default:               load_size = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] store_size(store_op_t op);
    case (op)
      STORE_BYTE: store_size = 2'd0;
      STORE_HALF: store_size = 2'd1;
      STORE_WORD: store_size = 2'd2;
      default:    store_size = 2'd3;
    endcase
  endfunction

  function automatic logic misaligned(logic [1:0] size, logic [2:0] a);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a[1:0];
      default: misaligned = |a[2:0];
    endcase
  endfunction

  // Unshifted byte-enable pattern for a given access size.
  function automatic logic [7:0] be_mask(logic [1:0] size);
    case (size)
      2'd0:    be_mask = 8'h01;
      2'd1:    be_mask = 8'h03;
      2'd2:    be_mask = 8'h0F;
      default: be_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// lsu_load_align: combinational load-lane extraction. Shifts the bus word
// down by the captured byte offset and sign/zero-extends per load_op.
//   rdata   in  DATA_W  raw bus read data
//   offset  in  OFF_W   byte offset of the access within the bus word
//   load_op in  enum    load flavour
//   data    out DATA_W  register-ready load result
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  load_op_t          load_op,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  // Keep the low 'bits' bits; optionally replicate bit bits-1 above them.
  function automatic logic [DATA_W-1:0] ext(logic [DATA_W-1:0] v, int bits, logic sgn);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b1}} >> (DATA_W - bits);
    ext  = v & mask;
    if (sgn && v[bits-1]) ext = ext | ~mask;
  endfunction

  always_comb begin
    data = lane;
    case (load_op)
      LOAD_BYTE:  data = ext(lane, 8, 1'b1);
      LOAD_BYTEU: data = ext(lane, 8, 1'b0);
      LOAD_HALF:  data = ext(lane, 16, 1'b1);
      LOAD_HALFU: data = ext(lane, 16, 1'b0);
      LOAD_WORD:  data = ext(lane, 32, 1'b1);
      LOAD_WORDU: data = ext(lane, 32, 1'b0);
      default:    data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: handshaked memory stage. Takes one op at a time from the
// pipeline, runs a req/gnt/rvalid bus transaction with byte enables and
// lane-replicated store data, and returns the extended load result, a
// pass-through value, or an exception (misaligned, bus error, timeout).
//   pipeline: req_valid/req_ready, mem_op/load_op/store_op, alu_result,
//             reg_data in; rsp_valid/write_out, exc_valid/exc_cause, busy out
//   bus:      bus_req/we/addr/be/wdata out; bus_gnt/rvalid/err/rdata in
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  memory_op_t          mem_op,
  input  load_op_t            load_op,
  input  store_op_t           store_op,
  input  logic [ADDR_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   reg_data,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   write_out,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic                busy,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MIN_W = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

  // Bus request bundle; declared here so its widths follow the parameters.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } data_bus_req_t;

  lsu_state_t        state, state_n;
  data_bus_req_t     bus_q, bus_n;
  logic              is_load_q, is_load_n;
  load_op_t          ld_op_q, ld_op_n;
  logic [OFF_W-1:0]  off_q, off_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              rsp_valid_n, exc_valid_n;
  lsu_exc_t          exc_q, exc_n;
  logic [DATA_W-1:0] write_out_n;

  // Request decode
  logic              is_load, is_store, misal, wide_bad, tmo_hit;
  logic [1:0]        size;
  logic [7:0]        be_full;
  logic [BE_W-1:0]   be_req;
  logic [DATA_W-1:0] wdata_req, load_data;
  logic [OFF_W-1:0]  off_req;

  assign is_load  = (mem_op == MEM_LOAD_OP);
  assign is_store = (mem_op == MEM_STORE_OP);
  assign size     = is_load ? load_size(load_op) : store_size(store_op);
  assign off_req  = alu_result[OFF_W-1:0];
  assign be_full  = be_mask(size);
  assign be_req   = be_full[BE_W-1:0] << off_req;

  // 64-bit accesses (and the zero-extending word load) only exist on a
  // 64-bit bus; on a 32-bit bus they are reported as misaligned.
  assign wide_bad = (DATA_W == 32) &&
                    ((is_load && (load_op == LOAD_WORDU || load_op == LOAD_DWORD)) ||
                     (is_store && store_op == STORE_DWORD));
  assign misal    = misaligned(size, alu_result[2:0]) || wide_bad;

  // Replicating the store source across all lanes means the byte enables
  // alone select the target bytes; no per-offset shifter is needed.
  always_comb begin
    case (size)
      2'd0:    wdata_req = {BE_W{reg_data[7:0]}};
      2'd1:    wdata_req = {(BE_W/2){reg_data[15:0]}};
      2'd2:    wdata_req = {(BE_W/4){reg_data[31:0]}};
      default: wdata_req = reg_data;
    endcase
  end

  // Counter spans REQ and RESP; it expires after TIMEOUT cycles there.
  assign tmo_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (bus_rdata),
    .offset  (off_q),
    .load_op (ld_op_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    bus_n       = bus_q;
    is_load_n   = is_load_q;
    ld_op_n     = ld_op_q;
    off_n       = off_q;
    cnt_n       = cnt_q;
    rsp_valid_n = 1'b0;
    exc_valid_n = 1'b0;
    exc_n       = exc_q;
    write_out_n = write_out;
    case (state)
      LSU_IDLE: begin
        if (req_valid) begin
          if (!is_load && !is_store) begin
            rsp_valid_n = 1'b1;
            write_out_n = '0;
            write_out_n[MIN_W-1:0] = alu_result[MIN_W-1:0];
          end else if (misal) begin
            exc_valid_n = 1'b1;
            exc_n       = is_load ? EXC_LOAD_MISALIGNED : EXC_STORE_MISALIGNED;
          end else begin
            bus_n.req   = 1'b1;
            bus_n.we    = is_store;
            bus_n.addr  = {alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_n.be    = be_req;
            bus_n.wdata = is_store ? wdata_req : '0;
            is_load_n   = is_load;
            ld_op_n     = load_op;
            off_n       = off_req;
            cnt_n       = '0;
            state_n     = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        cnt_n = cnt_q + CNT_W'(1);
        // gnt takes priority over an expiring timeout in the same cycle
        if (bus_gnt) begin
          bus_n.req = 1'b0;
          bus_n.we  = 1'b0;
          state_n   = LSU_RESP;
        end else if (tmo_hit) begin
          bus_n.req   = 1'b0;
          bus_n.we    = 1'b0;
          exc_valid_n = 1'b1;
          exc_n       = EXC_BUS_TIMEOUT;
          state_n     = LSU_IDLE;
        end
      end
      LSU_RESP: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_n = LSU_IDLE;
          if (bus_err) begin
            exc_valid_n = 1'b1;
            exc_n       = EXC_BUS_ERROR;
          end else begin
            rsp_valid_n = 1'b1;
            write_out_n = is_load_q ? load_data : '0;
          end
        end else if (tmo_hit) begin
          exc_valid_n = 1'b1;
          exc_n       = EXC_BUS_TIMEOUT;
          state_n     = LSU_IDLE;
        end
      end
      default: state_n = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q     <= '0;
      is_load_q <= 1'b0;
      ld_op_q   <= LOAD_BYTE;
      off_q     <= '0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      exc_valid <= 1'b0;
      exc_q     <= EXC_LOAD_MISALIGNED;
      write_out <= '0;
    end else begin
      bus_q     <= bus_n;
      is_load_q <= is_load_n;
      ld_op_q   <= ld_op_n;
      off_q     <= off_n;
      cnt_q     <= cnt_n;
      rsp_valid <= rsp_valid_n;
      exc_valid <= exc_valid_n;
      exc_q     <= exc_n;
      write_out <= write_out_n;
    end
  end

  assign req_ready = (state == LSU_IDLE);
  assign busy      = (state != LSU_IDLE);
  assign exc_cause = exc_q;
  assign bus_req   = bus_q.req;
  assign bus_we    = bus_q.we;
  assign bus_addr  = bus_q.addr;
  assign bus_be    = bus_q.be;
  assign bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: three instances (32-bit, 32-bit with TIMEOUT=4, 64-bit)
// share op and bus inputs; only the addressed one sees req_valid. Expected
// responses are queued at issue and popped by a negedge monitor.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] rv;
  memory_op_t mem_op;
  load_op_t   load_op;
  store_op_t  store_op;
  logic [31:0] alu;
  logic [63:0] regd, rdata;
  logic gnt, rvalid, berr;

  logic rdy0, rsp0, exc0, busy0, breq0, bwe0;
  logic [31:0] wo0, baddr0, bwd0;
  logic [1:0] ec0;
  logic [3:0] bbe0;
  logic rdy1, rsp1, exc1, busy1, breq1, bwe1;
  logic [31:0] wo1, baddr1, bwd1;
  logic [1:0] ec1;
  logic [3:0] bbe1;
  logic rdy2, rsp2, exc2, busy2, breq2, bwe2;
  logic [63:0] wo2, bwd2;
  logic [31:0] baddr2;
  logic [1:0] ec2;
  logic [7:0] bbe2;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy0),
    .mem_op(mem_op), .load_op(load_op), .store_op(store_op),
    .alu_result(alu), .reg_data(regd[31:0]), .rsp_valid(rsp0), .write_out(wo0),
    .exc_valid(exc0), .exc_cause(ec0), .busy(busy0), .bus_req(breq0), .bus_we(bwe0),
    .bus_addr(baddr0), .bus_be(bbe0), .bus_wdata(bwd0), .bus_gnt(gnt),
    .bus_rvalid(rvalid), .bus_err(berr), .bus_rdata(rdata[31:0]));

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy1),
    .mem_op(mem_op), .load_op(load_op), .store_op(store_op),
    .alu_result(alu), .reg_data(regd[31:0]), .rsp_valid(rsp1), .write_out(wo1),
    .exc_valid(exc1), .exc_cause(ec1), .busy(busy1), .bus_req(breq1), .bus_we(bwe1),
    .bus_addr(baddr1), .bus_be(bbe1), .bus_wdata(bwd1), .bus_gnt(gnt),
    .bus_rvalid(rvalid), .bus_err(berr), .bus_rdata(rdata[31:0]));

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy2),
    .mem_op(mem_op), .load_op(load_op), .store_op(store_op),
    .alu_result(alu), .reg_data(regd), .rsp_valid(rsp2), .write_out(wo2),
    .exc_valid(exc2), .exc_cause(ec2), .busy(busy2), .bus_req(breq2), .bus_we(bwe2),
    .bus_addr(baddr2), .bus_be(bbe2), .bus_wdata(bwd2), .bus_gnt(gnt),
    .bus_rvalid(rvalid), .bus_err(berr), .bus_rdata(rdata));

  typedef struct {
    int          id;
    bit          exc;
    logic [1:0]  cause;
    logic [63:0] data;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic exp_rsp(int id, logic [63:0] d);
    sbq.push_back('{id, 1'b0, 2'd0, d});
  endtask

  task automatic exp_exc(int id, logic [1:0] c);
    sbq.push_back('{id, 1'b1, c, 64'd0});
  endtask

  task automatic mon(int id, logic r, logic e, logic [1:0] c, logic [63:0] d);
    exp_t x;
    if (r && e) chk($sformatf("excl_dut%0d", id), 64'(r & e), 64'd0);
    if (r || e) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out dut%0d: got rsp=%b exc=%b cause=%0d data=%h want none at %0t",
                 id, r, e, c, d, $time);
      end else begin
        x = sbq.pop_front();
        chk("sb_id", 64'(id), 64'(x.id));
        chk("sb_kind", 64'(e), 64'(x.exc));
        if (x.exc) chk("sb_cause", 64'(c), 64'(x.cause));
        else       chk("sb_data", d, x.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rsp0, exc0, ec0, {32'd0, wo0});
    mon(1, rsp1, exc1, ec1, {32'd0, wo1});
    mon(2, rsp2, exc2, ec2, wo2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int id, memory_op_t m, load_op_t l, store_op_t s,
                       logic [31:0] a, logic [63:0] d);
    logic r;
    r = (id == 0) ? rdy0 : (id == 1) ? rdy1 : rdy2;
    chk("req_ready", 64'(r), 64'd1);
    mem_op = m; load_op = l; store_op = s; alu = a; regd = d;
    rv = 3'b000;
    rv[id] = 1'b1;
    tick();
    rv = 3'b000;
  endtask

  // gnt after gw idle REQ cycles, rvalid after rw idle RESP cycles
  task automatic bus(int gw, int rw, logic [63:0] rd, logic err);
    repeat (gw) tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    repeat (rw) tick();
    rvalid = 1'b1; rdata = rd; berr = err;
    tick();
    rvalid = 1'b0; berr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rv = 3'b000; gnt = 1'b0; rvalid = 1'b0; berr = 1'b0;
    mem_op = MEM_SKIP_OP; load_op = LOAD_BYTE; store_op = STORE_BYTE;
    alu = '0; regd = '0; rdata = '0;
    #12;
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_outs", {busy0, breq0, rsp0, exc0, ec0, busy2, breq2}, 64'd0);
    chk("rst_wout", {wo0, wo2[31:0]}, 64'd0);
    rst = 1'b0;
    tick();

    // Store byte: lane 3, replicated data
    exp_rsp(0, 64'd0);
    issue(0, MEM_STORE_OP, LOAD_BYTE, STORE_BYTE, 32'h1003, 64'hA5);
    chk("sb_req", {breq0, bwe0}, 64'h3);
    chk("sb_addr", baddr0, 32'h1000);
    chk("sb_be", bbe0, 4'h8);
    chk("sb_wdata", bwd0, 32'hA5A5A5A5);
    bus(0, 0, 64'd0, 1'b0);

    // Load extraction from 0x12F03456
    exp_rsp(0, 64'hFFFFFFF0);
    issue(0, MEM_LOAD_OP, LOAD_BYTE, STORE_BYTE, 32'h2002, 0);
    chk("lb_be", bbe0, 4'h4);
    bus(0, 0, 64'h12F03456, 1'b0);
    exp_rsp(0, 64'h000000F0);
    issue(0, MEM_LOAD_OP, LOAD_BYTEU, STORE_BYTE, 32'h2002, 0);
    bus(0, 0, 64'h12F03456, 1'b0);
    exp_rsp(0, 64'h000012F0);
    issue(0, MEM_LOAD_OP, LOAD_HALF, STORE_BYTE, 32'h2002, 0);
    chk("lh_be", bbe0, 4'hC);
    bus(0, 0, 64'h12F03456, 1'b0);
    exp_rsp(0, 64'h00000034);
    issue(0, MEM_LOAD_OP, LOAD_BYTE, STORE_BYTE, 32'h2001, 0);
    bus(0, 0, 64'h12F03456, 1'b0);
    exp_rsp(0, 64'h00003456);
    issue(0, MEM_LOAD_OP, LOAD_HALFU, STORE_BYTE, 32'h2000, 0);
    bus(0, 0, 64'h12F03456, 1'b0);
    exp_rsp(0, 64'h12F03456);
    issue(0, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h2000, 0);
    bus(0, 0, 64'h12F03456, 1'b0);

    // Misaligned / illegal-at-32 ops: exception next cycle, no bus request
    exp_exc(0, 2'd0);
    issue(0, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h3001, 0);
    chk("mis_noreq", 64'(breq0 | busy0), 64'd0);
    exp_exc(0, 2'd0);
    issue(0, MEM_LOAD_OP, LOAD_HALF, STORE_BYTE, 32'h3001, 0);
    exp_exc(0, 2'd1);
    issue(0, MEM_STORE_OP, LOAD_BYTE, STORE_WORD, 32'h3002, 0);
    exp_exc(0, 2'd1);
    issue(0, MEM_STORE_OP, LOAD_BYTE, STORE_HALF, 32'h3003, 0);
    exp_exc(0, 2'd0);
    issue(0, MEM_LOAD_OP, LOAD_WORDU, STORE_BYTE, 32'h3000, 0);
    exp_exc(0, 2'd1);
    issue(0, MEM_STORE_OP, LOAD_BYTE, STORE_DWORD, 32'h3000, 0);
    chk("mis_noreq2", 64'(breq0), 64'd0);
    tick();

    // Skip ops back to back
    exp_rsp(0, 64'hDEADBEEF);
    issue(0, MEM_SKIP_OP, LOAD_BYTE, STORE_BYTE, 32'hDEADBEEF, 0);
    exp_rsp(0, 64'h12345678);
    issue(0, MEM_SKIP_OP, LOAD_BYTE, STORE_BYTE, 32'h12345678, 0);
    tick();

    // Grant stall: 5 cycles without gnt, rvalid two cycles after gnt
    exp_rsp(0, 64'hCAFEF00D);
    issue(0, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h4000, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {busy0, breq0, bwe0}, 64'h6);
      chk("stall_addr", baddr0, 32'h4000);
      chk("stall_be", bbe0, 4'hF);
      tick();
    end
    gnt = 1'b1; tick(); gnt = 1'b0;
    chk("resp_busy", {busy0, breq0}, 64'h2);
    tick();
    rvalid = 1'b1; rdata = 64'hCAFEF00D;
    chk("pre_rsp", 64'(rsp0), 64'd0);
    tick();
    rvalid = 1'b0;
    chk("rsp_pulse", 64'(rsp0), 64'd1);
    tick();
    chk("rsp_once", 64'(rsp0), 64'd0);

    // Bus error
    exp_exc(0, 2'd2);
    issue(0, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h5000, 0);
    bus(1, 0, 64'h0, 1'b1);

    // Timeout on the TIMEOUT=4 instance; a late rvalid is ignored
    exp_exc(1, 2'd3);
    issue(1, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h6000, 0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", 64'(breq1), 64'd1);
      tick();
    end
    chk("tmo_exc", {exc1, ec1, breq1, busy1}, 64'h1C);
    rvalid = 1'b1; gnt = 1'b1;
    tick();
    rvalid = 1'b0; gnt = 1'b0;
    tick();

    // Reset in RESP, then reset in REQ; late response ignored afterwards
    issue(0, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h7000, 0);
    gnt = 1'b1; tick(); gnt = 1'b0;
    chk("pre_rst_busy", 64'(busy0), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_resp", {busy0, breq0, rdy0}, 64'h1);
    #1 rst = 1'b0;
    tick();
    issue(0, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'h7004, 0);
    chk("pre_rst_req", 64'(breq0), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_req", {busy0, breq0}, 64'h0);
    #1 rst = 1'b0;
    tick();
    rvalid = 1'b1; tick(); rvalid = 1'b0;
    exp_rsp(0, 64'd0);
    issue(0, MEM_STORE_OP, LOAD_BYTE, STORE_HALF, 32'h1002, 64'hBEEF);
    chk("post_rst_be", bbe0, 4'hC);
    chk("post_rst_wd", bwd0, 32'hBEEFBEEF);
    bus(0, 0, 64'd0, 1'b0);

    // 64-bit instance
    exp_rsp(2, 64'h1122334455667788);
    issue(2, MEM_LOAD_OP, LOAD_DWORD, STORE_BYTE, 32'h8, 0);
    chk("ld_addr", baddr2, 32'h8);
    chk("ld_be", bbe2, 8'hFF);
    bus(0, 0, 64'h1122334455667788, 1'b0);
    exp_rsp(2, 64'hFFFFFFFF80000001);
    issue(2, MEM_LOAD_OP, LOAD_WORD, STORE_BYTE, 32'hC, 0);
    chk("lw64_be", bbe2, 8'hF0);
    bus(0, 0, 64'h8000000112345678, 1'b0);
    exp_rsp(2, 64'h0000000080000001);
    issue(2, MEM_LOAD_OP, LOAD_WORDU, STORE_BYTE, 32'hC, 0);
    bus(0, 0, 64'h8000000112345678, 1'b0);
    exp_rsp(2, 64'd0);
    issue(2, MEM_STORE_OP, LOAD_BYTE, STORE_BYTE, 32'hD, 64'h5A);
    chk("sb64_be", bbe2, 8'h20);
    chk("sb64_wd", bwd2, 64'h5A5A5A5A5A5A5A5A);
    bus(0, 0, 64'd0, 1'b0);
    exp_exc(2, 2'd0);
    issue(2, MEM_LOAD_OP, LOAD_DWORD, STORE_BYTE, 32'hC, 0);
    exp_exc(2, 2'd1);
    issue(2, MEM_STORE_OP, LOAD_BYTE, STORE_DWORD, 32'h4, 0);
    exp_rsp(2, 64'h0000000089ABCDEF);
    issue(2, MEM_SKIP_OP, LOAD_BYTE, STORE_BYTE, 32'h89ABCDEF, 0);

    repeat (3) tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised, handshaked successor to the combinational memory stage. It accepts one memory-stage operation at a time from the pipeline and drives a request/grant/response data bus with byte enables and lane-correct store data. It sign- or zero-extends load data from the correct byte lane and reports misalignment, bus errors and timeouts as exceptions. It sits between EX/MEM and the data memory, and stalls the pipeline while a bus transaction is outstanding.

## Interface
- DATA_W, 32: bus and register width, 32 or 64. Double-word ops are legal only at 64.
- ADDR_W, 32: byte-address width.
- TIMEOUT, 255: cycles allowed in REQ+RESP before abort. 0 disables the timeout.
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents an op.
- req_ready  out  1  op accepted when req_valid && req_ready.
- mem_op / load_op / store_op  in  enum  operation selectors (memory_op_t, load_op_t, store_op_t).
- alu_result  in  ADDR_W  effective address, or the pass-through value for MEM_SKIP_OP.
- reg_data  in  DATA_W  store source.
- rsp_valid  out  1  one-cycle pulse; write_out is valid. No back-pressure.
- write_out  out  DATA_W  load result, pass-through value, or 0 for stores.
- exc_valid  out  1  one-cycle pulse, mutually exclusive with rsp_valid.
- exc_cause  out  2  0 load misaligned, 1 store misaligned, 2 bus error, 3 bus timeout.
- busy  out  1  high in REQ or RESP; drives the pipeline stall.
- bus_req, bus_we  out  1  request and write strobe.
- bus_addr  out  ADDR_W  address aligned down to DATA_W/8.
- bus_be  out  DATA_W/8  byte enables.
- bus_wdata  out  DATA_W  lane-shifted store data.
- bus_gnt, bus_rvalid, bus_err  in  1  grant, response valid, and error (sampled with rvalid).
- bus_rdata  in  DATA_W  read data.

## Operation
- FSM states: IDLE, REQ, RESP. req_ready = (state == IDLE).
- IDLE, accepting MEM_SKIP_OP: register write_out = alu_result; rsp_valid next cycle; stay in IDLE.
- IDLE, accepting a misaligned op: exc_valid next cycle with cause 0 (load) or 1 (store); no bus activity.
  - Misaligned means: half-word op with addr[0] set; word op with addr[1:0] ≠ 0; dword op with addr[2:0] ≠ 0.
  - A dword op or LOAD_WORDU at DATA_W=32 also raises the misaligned cause.
- IDLE, accepting a legal load or store: capture op, byte offset, bus_addr, bus_be and bus_wdata; go to REQ.
- REQ: hold bus_req and all bus outputs stable until bus_gnt, then go to RESP.
- RESP: wait for bus_rvalid.
  - rvalid with bus_err: exc cause 2.
  - Load: extract the lane at the captured offset, extend per load_op, pulse rsp_valid.
  - Store: write_out = 0, pulse rsp_valid.
  - Go to IDLE.
- Store lanes: bus_wdata replicates the byte or half across all lanes; bus_be = mask << offset (byte 1, half 3, word 0xF, dword 0xFF).
- Timeout: the counter clears on entering REQ and increments each cycle in REQ and RESP. When it reaches TIMEOUT: cause 3, go to IDLE.
- bus_rvalid and bus_gnt are ignored in IDLE. This covers late responses after a timeout or a reset.

## Timing
- Reset values: state IDLE; req_ready 1; all other outputs 0, including bus_req, rsp_valid, exc_valid, write_out, exc_cause, busy.
- Reset takes effect immediately; bus_req drops in the same cycle.
- Skip and misaligned ops: accepted in cycle N, response in N+1; a new op may be accepted in N+1.
- Bus ops: accepted in N, bus_req rises in N+1. With gnt in cycle G and rvalid in cycle R (R ≥ G+1), the response appears in R+1. Minimum latency is 3 cycles; back-to-back throughput is one op per 3 cycles.
- Same-cycle gnt in REQ and the timeout: gnt wins.
- Same-cycle rvalid in RESP and the timeout: rvalid wins.
- rsp_valid and exc_valid are registered and never both high.

## Structure
- Extend params.sv with: LOAD_WORDU, LOAD_DWORD, STORE_DWORD; lsu_state_t; lsu_exc_t; and a data_bus_req_t struct (req, we, addr, be, wdata).
- Sub-module lsu_load_align: purely combinational lane extraction and sign/zero extension, parametrised on DATA_W.

## Test plan
- SB x=0x000000A5 at 0x1003 → bus_addr 0x1000, be 0x8, wdata 0xA5A5A5A5, rsp_valid with write_out 0.
- LB at 0x2002 with rdata 0x12F03456 → write_out 0xFFFFFFF0; LBU gives 0x000000F0; LH at 0x2002 gives 0x000012F0.
- LW at 0x3001 → exc_valid cause 0 one cycle after accept; bus_req never rises.
- Load with gnt held low 5 cycles, then rvalid 2 cycles later → bus outputs stable throughout, busy high, rsp_valid exactly 1 cycle after rvalid.
- TIMEOUT=4 and no gnt → exc cause 3 after 4 cycles in REQ; an rvalid arriving afterwards produces no response.
- rst asserted in RESP → bus_req and busy low immediately; the next op after release completes normally; DATA_W=64 LD at 0x8 → be 0xFF.
